// File: rtl/pwm_sched_pkg.sv
// Shared motor-drive types and constants for the PWM duty schedulers.
// Latency: n/a (package only).
// Backpressure: n/a.
package pwm_sched_pkg;

    localparam int DUTY_W = 11;
    localparam logic [DUTY_W-1:0] DUTY_MID = 11'd1024;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } state_t;

endpackage

// File: rtl/duty_slew.sv
// Clamps a signed torque command into duty space and computes one slew step toward the target.
// Latency: combinational.
// Backpressure: none.
module duty_slew
    import pwm_sched_pkg::*;
#(
    parameter int SLEW_STEP = 64,
    parameter int MIN_DUTY  = 64,
    parameter int MAX_DUTY  = 1984
) (
    input  logic signed [11:0]       cmd,
    input  logic        [DUTY_W-1:0] duty,
    input  logic        [DUTY_W-1:0] tgt,
    output logic        [DUTY_W-1:0] cmd_duty,
    output logic        [DUTY_W-1:0] duty_next
);

    logic signed [12:0] sum;
    logic [DUTY_W:0]    diff;

    always_comb begin
        // 13-bit signed sum so -2048 + 1024 and +2047 + 1024 both fit
        sum = $signed({cmd[11], cmd}) + 13'sd1024;
        if (sum < 13'(MIN_DUTY)) begin
            cmd_duty = DUTY_W'(MIN_DUTY);
        end else if (sum > 13'(MAX_DUTY)) begin
            cmd_duty = DUTY_W'(MAX_DUTY);
        end else begin
            cmd_duty = sum[DUTY_W-1:0];
        end
    end

    always_comb begin
        diff      = '0;
        duty_next = duty;
        if (tgt > duty) begin
            diff      = {1'b0, tgt} - {1'b0, duty};
            duty_next = (diff > 12'(SLEW_STEP)) ? duty + DUTY_W'(SLEW_STEP) : tgt;
        end else if (tgt < duty) begin
            diff      = {1'b0, duty} - {1'b0, tgt};
            duty_next = (diff > 12'(SLEW_STEP)) ? duty - DUTY_W'(SLEW_STEP) : tgt;
        end
    end

endmodule

// File: rtl/pwm_sched.sv
// Duty scheduler and overcurrent protection for one PWM generator; duty changes only at period end.
// Latency: duty/drv_en/fault update one clk after the PWM_synch cycle; cmd captured one clk after cmd_vld.
// Backpressure: none; cmd_vld is accepted in every state and every cycle.
module pwm_sched
    import pwm_sched_pkg::*;
#(
    parameter int SLEW_STEP    = 64,
    parameter int MIN_DUTY     = 64,
    parameter int MAX_DUTY     = 1984,
    parameter int OVR_LIMIT    = 4,
    parameter int COOL_PERIODS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [11:0]       cmd,
    input  logic              cmd_vld,
    input  logic              PWM_synch,
    input  logic              OVR_I_blank_n,
    input  logic              OVR_I,
    input  logic              clr_fault,
    output logic [DUTY_W-1:0] duty,
    output logic              drv_en,
    output logic              fault,
    output logic [2:0]        ovr_cnt
);

    state_t            state;
    logic [DUTY_W-1:0] tgt;
    logic [DUTY_W-1:0] cmd_duty;
    logic [DUTY_W-1:0] duty_next;
    logic [3:0]        cool_cnt;
    logic              ovr_flag;
    logic              ovr_hit;
    logic              period_bad;
    logic [2:0]        cnt_next;

    duty_slew #(
        .SLEW_STEP (SLEW_STEP),
        .MIN_DUTY  (MIN_DUTY),
        .MAX_DUTY  (MAX_DUTY)
    ) u_duty_slew (
        .cmd       ($signed(cmd)),
        .duty      (duty),
        .tgt       (tgt),
        .cmd_duty  (cmd_duty),
        .duty_next (duty_next)
    );

    // An event on the boundary cycle itself still counts toward the closing period
    always_comb begin
        ovr_hit    = OVR_I & OVR_I_blank_n;
        period_bad = ovr_flag | ovr_hit;
        if (!period_bad) begin
            cnt_next = 3'd0;
        end else if (ovr_cnt >= 3'(OVR_LIMIT)) begin
            cnt_next = ovr_cnt;
        end else begin
            cnt_next = ovr_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            duty     <= DUTY_MID;
            tgt      <= DUTY_MID;
            drv_en   <= 1'b0;
            fault    <= 1'b0;
            ovr_cnt  <= 3'd0;
            cool_cnt <= 4'd0;
            ovr_flag <= 1'b0;
        end else begin
            if (cmd_vld) begin
                tgt <= cmd_duty;
            end
            if (PWM_synch) begin
                ovr_flag <= 1'b0;
                case (state)
                    IDLE: begin
                        duty   <= DUTY_MID;
                        drv_en <= en;
                        if (en) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        ovr_cnt <= cnt_next;
                        if (cnt_next == 3'(OVR_LIMIT)) begin
                            state    <= FAULT;
                            duty     <= DUTY_MID;
                            drv_en   <= 1'b0;
                            fault    <= 1'b1;
                            cool_cnt <= 4'd0;
                        end else if (!en) begin
                            state  <= IDLE;
                            duty   <= DUTY_MID;
                            drv_en <= 1'b0;
                        end else begin
                            duty <= duty_next;
                        end
                    end
                    FAULT: begin
                        if (clr_fault && !en && cool_cnt == 4'(COOL_PERIODS)) begin
                            state   <= IDLE;
                            fault   <= 1'b0;
                            ovr_cnt <= 3'd0;
                        end else if (cool_cnt != 4'(COOL_PERIODS)) begin
                            cool_cnt <= cool_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        duty   <= DUTY_MID;
                        drv_en <= 1'b0;
                    end
                endcase
            end else if (ovr_hit) begin
                ovr_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_sched.sv
// Directed bench for pwm_sched: integer reference model compared every cycle plus literal spot checks.
module tb_pwm_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [11:0] cmd = '0;
    logic        cmd_vld = 1'b0;
    logic        PWM_synch = 1'b0;
    logic        OVR_I_blank_n = 1'b0;
    logic        OVR_I = 1'b0;
    logic        clr_fault = 1'b0;
    logic [10:0] duty;
    logic        drv_en;
    logic        fault;
    logic [2:0]  ovr_cnt;

    int vectors = 0;
    int miscompares = 0;
    int per = 2048;
    int cnt = 0;
    bit armed = 1'b0;

    // Reference model state (mode: 0 idle, 1 run, 2 fault)
    int m_tgt = 1024, m_duty = 1024, m_cnt = 0, m_cool = 0, m_mode = 0;
    bit m_drv = 0, m_fault = 0, m_flag = 0;

    pwm_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .cmd           (cmd),
        .cmd_vld       (cmd_vld),
        .PWM_synch     (PWM_synch),
        .OVR_I_blank_n (OVR_I_blank_n),
        .OVR_I         (OVR_I),
        .clr_fault     (clr_fault),
        .duty          (duty),
        .drv_en        (drv_en),
        .fault         (fault),
        .ovr_cnt       (ovr_cnt)
    );

    always #5 clk = ~clk;

    // PWM generator stand-in: period end at count per-1, sense blanked for first 16 counts
    initial begin
        forever begin
            @(negedge clk);
            cnt = (cnt >= per - 1) ? 0 : cnt + 1;
            PWM_synch = (cnt == per - 1);
            OVR_I_blank_n = (cnt >= 16);
        end
    end

    always @(posedge clk) begin
        int c, d;
        bit hit, bad;
        if (!rst_n) begin
            m_tgt = 1024; m_duty = 1024; m_cnt = 0; m_cool = 0; m_mode = 0;
            m_drv = 0; m_fault = 0; m_flag = 0;
        end else begin
            hit = OVR_I && OVR_I_blank_n;
            if (PWM_synch) begin
                bad = m_flag || hit;
                m_flag = 0;
                if (m_mode == 0) begin
                    if (en) begin m_mode = 1; m_drv = 1; end
                end else if (m_mode == 1) begin
                    m_cnt = bad ? ((m_cnt + 1 > 4) ? 4 : m_cnt + 1) : 0;
                    if (m_cnt == 4) begin
                        m_mode = 2; m_duty = 1024; m_drv = 0; m_fault = 1; m_cool = 0;
                    end else if (!en) begin
                        m_mode = 0; m_duty = 1024; m_drv = 0;
                    end else begin
                        d = m_tgt - m_duty;
                        if (d > 64) d = 64;
                        if (d < -64) d = -64;
                        m_duty = m_duty + d;
                    end
                end else begin
                    if (clr_fault && !en && m_cool == 8) begin
                        m_mode = 0; m_fault = 0; m_cnt = 0;
                    end else if (m_cool < 8) begin
                        m_cool = m_cool + 1;
                    end
                end
            end else if (hit) begin
                m_flag = 1;
            end
            if (cmd_vld) begin
                c = int'($signed(cmd)) + 1024;
                m_tgt = (c < 64) ? 64 : (c > 1984) ? 1984 : c;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            vectors++;
            if (duty !== 11'(m_duty) || drv_en !== m_drv || fault !== m_fault || ovr_cnt !== 3'(m_cnt)) begin
                miscompares++;
                if (miscompares < 20)
                    $display("FAIL model t=%0t: duty=%0d drv_en=%b fault=%b ovr_cnt=%0d expected duty=%0d drv_en=%b fault=%b ovr_cnt=%0d",
                             $time, duty, drv_en, fault, ovr_cnt, m_duty, m_drv, m_fault, m_cnt);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [11:0] act, input int exp);
        vectors++;
        if (act !== 12'(exp)) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_b(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!PWM_synch) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic strobe_cmd(input logic [11:0] v);
        @(negedge clk);
        cmd = v; cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    task automatic ovr_window();
        repeat (32) @(negedge clk);
        OVR_I = 1'b1;
        repeat (10) @(negedge clk);
        OVR_I = 1'b0;
    endtask

    task automatic ovr_blanked();
        OVR_I = 1'b1;
        repeat (8) @(negedge clk);
        OVR_I = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        armed = 1'b1;
        chk("reset_duty", 12'(duty), 1024);
        chk("reset_drv_en", 12'(drv_en), 0);
        chk("reset_fault", 12'(fault), 0);
        chk("reset_ovr_cnt", 12'(ovr_cnt), 0);
        rst_n = 1'b1;

        // Slew up with a full 2048-cycle period
        en = 1'b1;
        strobe_cmd(12'd512);
        wait_b(1);
        chk("run_drv_en", 12'(drv_en), 1);
        chk("run_duty_mid", 12'(duty), 1024);
        for (int k = 1; k <= 8; k++) begin
            wait_b(1);
            chk("slew_up", 12'(duty), 1024 + 64 * k);
        end
        wait_b(1);
        chk("slew_hold", 12'(duty), 1536);

        // Clamp high, then clamp low with negative slew
        per = 128;
        strobe_cmd(12'd1500);
        wait_b(7);
        chk("clamp_hi", 12'(duty), 1984);
        wait_b(1);
        chk("clamp_hi_hold", 12'(duty), 1984);
        strobe_cmd(12'h800);
        wait_b(29);
        chk("slew_down", 12'(duty), 128);
        wait_b(1);
        chk("clamp_lo", 12'(duty), 64);
        wait_b(2);
        chk("clamp_lo_hold", 12'(duty), 64);

        // Events inside the blanking window are ignored
        for (int k = 0; k < 3; k++) begin
            ovr_blanked();
            wait_b(1);
            chk("blanked_cnt", 12'(ovr_cnt), 0);
        end

        // bad, bad, clean, bad
        ovr_window(); wait_b(1); chk("seq_cnt1", 12'(ovr_cnt), 1);
        ovr_window(); wait_b(1); chk("seq_cnt2", 12'(ovr_cnt), 2);
        wait_b(1);               chk("seq_cnt0", 12'(ovr_cnt), 0);
        ovr_window(); wait_b(1); chk("seq_cnt1b", 12'(ovr_cnt), 1);
        chk("seq_no_fault", 12'(fault), 0);
        wait_b(1);               chk("seq_clean", 12'(ovr_cnt), 0);

        // Four consecutive bad periods trip the fault
        for (int k = 1; k <= 3; k++) begin
            ovr_window(); wait_b(1);
            chk("trip_cnt", 12'(ovr_cnt), k);
        end
        ovr_window(); wait_b(1);
        chk("trip_fault", 12'(fault), 1);
        chk("trip_drv_en", 12'(drv_en), 0);
        chk("trip_duty", 12'(duty), 1024);
        chk("trip_ovr_cnt", 12'(ovr_cnt), 4);

        // Early clear, clear with en high, then a valid clear
        wait_b(3);
        clr_fault = 1'b1; wait_b(1); clr_fault = 1'b0;
        chk("clr_early", 12'(fault), 1);
        wait_b(4);
        clr_fault = 1'b1; wait_b(1); clr_fault = 1'b0;
        chk("clr_en_high", 12'(fault), 1);
        en = 1'b0;
        clr_fault = 1'b1; wait_b(1); clr_fault = 1'b0;
        chk("clr_ok_fault", 12'(fault), 0);
        chk("clr_ok_cnt", 12'(ovr_cnt), 0);
        chk("clr_ok_drv_en", 12'(drv_en), 0);

        // Reset mid-ramp
        en = 1'b1;
        strobe_cmd(12'd512);
        wait_b(1);
        chk("rerun_duty", 12'(duty), 1024);
        wait_b(4);
        chk("ramp_1280", 12'(duty), 1280);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_duty", 12'(duty), 1024);
        chk("rst_drv_en", 12'(drv_en), 0);
        repeat (5) @(negedge clk);
        chk("rst_no_reentry", 12'(drv_en), 0);
        wait_b(1);
        chk("reentry_drv_en", 12'(drv_en), 1);

        // cmd_vld coincident with the boundary: step uses the old target
        @(posedge clk);
        while (cnt != per - 2) @(posedge clk);
        @(negedge clk);
        cmd = 12'd256; cmd_vld = 1'b1;
        @(negedge clk);
        cmd_vld = 1'b0;
        chk("coincident_old_tgt", 12'(duty), 1024);
        wait_b(1);
        chk("coincident_new_tgt", 12'(duty), 1088);

        // Drop en: back to idle at the next boundary
        en = 1'b0;
        wait_b(1);
        chk("idle_drv_en", 12'(drv_en), 0);
        chk("idle_duty", 12'(duty), 1024);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
